// File: rtl/simd_seq_pkg.sv
// Shared types and constants for the SIMD instruction sequencer.
// The instruction and micro-op records and the FSM state type all live here,
// so the buffer and the sequencer agree on field layout.
package simd_seq_pkg;

    localparam int SEQ_OPW   = 4;
    localparam int SEQ_RW    = 6;
    localparam int SEQ_CW    = 8;
    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W     = 1;

    typedef struct packed {
        logic [SEQ_OPW-1:0] opcode;
        logic [SEQ_RW-1:0]  dst;
        logic [SEQ_RW-1:0]  src0;
        logic [SEQ_RW-1:0]  src1;
        logic [SEQ_CW-1:0]  rep;
    } inst_t;

    typedef struct packed {
        logic [SEQ_OPW-1:0] opcode;
        logic [SEQ_RW-1:0]  dst;
        logic [SEQ_RW-1:0]  src0;
        logic [SEQ_RW-1:0]  src1;
        logic               last;
    } uop_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // The first micro-op of an instruction uses its base registers unchanged;
    // a zero repeat count means this first micro-op is also the last one.
    function automatic uop_t first_uop(input inst_t inst);
        uop_t u;
        u.opcode = inst.opcode;
        u.dst    = inst.dst;
        u.src0   = inst.src0;
        u.src1   = inst.src1;
        u.last   = (inst.rep == '0);
        return u;
    endfunction

endpackage

// File: rtl/simd_seq_fifo.sv
// Two-entry instruction buffer for the SIMD sequencer.
// The head entry stays in the buffer while it is being expanded. It is only
// popped once its final micro-op is accepted. The entry behind it is exposed
// as well, so the sequencer can load it on the same edge as the pop.
module simd_seq_fifo
    import simd_seq_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  logic             pop,
    input  inst_t            push_data,
    output inst_t            head,
    output inst_t            next,
    output logic [CNT_W-1:0] count
);

    inst_t            mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Storage, pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < BUF_DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign next = mem[rd_ptr + 1'b1];

endmodule

// File: rtl/simd_inst_sequencer.sv
// SIMD instruction sequencer.
// It accepts instructions from the driver into a two-entry buffer and expands
// each one into (rep+1) micro-ops. Each micro-op has its register indices
// offset by its position in the burst. Micro-ops are issued one per cycle
// from a registered issue stage.
// Optional feature: define SIMD_SEQ_STAT_EN to add saturating statistics
// counters for accepted instructions and stalled issue cycles.
module simd_inst_sequencer
    import simd_seq_pkg::*;
#(
    parameter int OPW = SEQ_OPW,
    parameter int RW  = SEQ_RW,
    parameter int CW  = SEQ_CW
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           inst_rdy,
    output logic           inst_ack,
    input  logic [OPW-1:0] inst_opcode,
    input  logic [RW-1:0]  inst_dst,
    input  logic [RW-1:0]  inst_src0,
    input  logic [RW-1:0]  inst_src1,
    input  logic [CW-1:0]  inst_rep,
    output logic           uop_rdy,
    input  logic           uop_ack,
    output logic [OPW-1:0] uop_opcode,
    output logic [RW-1:0]  uop_dst,
    output logic [RW-1:0]  uop_src0,
    output logic [RW-1:0]  uop_src1,
    output logic           uop_last,
    output logic           o_busy
`ifdef SIMD_SEQ_STAT_EN
    ,
    output logic [31:0]    o_stat_inst,
    output logic [31:0]    o_stat_stall
`endif
);

    inst_t            inst_in;
    inst_t            fifo_head;
    inst_t            fifo_next;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic             have_next;
    inst_t            next_src;

    state_t           state;
    uop_t             uop_q;
    logic             uop_valid;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    rep_q;

    assign inst_in = '{opcode: inst_opcode, dst: inst_dst, src0: inst_src0,
                       src1: inst_src1, rep: inst_rep};

    // Acceptance only looks at the pre-pop occupancy, so a full buffer never takes a push even if it pops this cycle.
    assign inst_ack = i_rst && inst_rdy && (fifo_count < CNT_W'(BUF_DEPTH));
    assign push     = inst_rdy && inst_ack;
    assign pop      = (state == ISSUE) && uop_ack && uop_q.last;

    simd_seq_fifo u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (push),
        .pop       (pop),
        .push_data (inst_in),
        .head      (fifo_head),
        .next      (fifo_next),
        .count     (fifo_count)
    );

    // Choose the instruction that follows the one finishing now: either the second buffered entry or the one arriving this cycle.
    always_comb begin
        have_next = 1'b0;
        next_src  = fifo_next;
        if (fifo_count == CNT_W'(2)) begin
            have_next = 1'b1;
        end else if (push) begin
            have_next = 1'b1;
            next_src  = inst_in;
        end
    end

    // Issue FSM: load an instruction, walk its micro-ops on each accept, and chain into the next instruction without a bubble.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            uop_q     <= '0;
            uop_valid <= 1'b0;
            idx       <= '0;
            rep_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_count != '0) begin
                        uop_q     <= first_uop(fifo_head);
                        rep_q     <= fifo_head.rep;
                        idx       <= '0;
                        uop_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (uop_ack) begin
                        if (!uop_q.last) begin
                            idx        <= idx + CW'(1);
                            uop_q.dst  <= uop_q.dst + RW'(1);
                            uop_q.src0 <= uop_q.src0 + RW'(1);
                            uop_q.src1 <= uop_q.src1 + RW'(1);
                            uop_q.last <= ((idx + CW'(1)) == rep_q);
                        end else if (have_next) begin
                            uop_q     <= first_uop(next_src);
                            rep_q     <= next_src.rep;
                            idx       <= '0;
                            uop_valid <= 1'b1;
                        end else begin
                            uop_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    uop_valid <= 1'b0;
                end
            endcase
        end
    end

    assign uop_rdy    = uop_valid;
    assign uop_opcode = uop_q.opcode;
    assign uop_dst    = uop_q.dst;
    assign uop_src0   = uop_q.src0;
    assign uop_src1   = uop_q.src1;
    assign uop_last   = uop_q.last;
    assign o_busy     = (fifo_count != '0) || uop_valid;

`ifdef SIMD_SEQ_STAT_EN
    // Saturating counters for accepted instructions and cycles where the lanes hold off a valid micro-op.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_stat_inst  <= '0;
            o_stat_stall <= '0;
        end else begin
            if (push && (o_stat_inst != '1)) begin
                o_stat_inst <= o_stat_inst + 32'd1;
            end
            if (uop_valid && !uop_ack && (o_stat_stall != '1)) begin
                o_stat_stall <= o_stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_simd_inst_sequencer.sv
// Self-checking bench for simd_inst_sequencer.
// Accepted instructions are expanded into expected micro-ops on a scoreboard
// queue. Every micro-op transfer is compared against the head of that queue.
// Honours SIMD_SEQ_STAT_EN when the design is built with it.
module tb_simd_inst_sequencer;

    localparam int OPW = 4;
    localparam int RW  = 6;
    localparam int CW  = 8;

    typedef logic [OPW+3*RW:0] exp_t;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b0;
    logic           inst_rdy = 1'b0;
    logic           inst_ack;
    logic [OPW-1:0] inst_opcode = '0;
    logic [RW-1:0]  inst_dst = '0;
    logic [RW-1:0]  inst_src0 = '0;
    logic [RW-1:0]  inst_src1 = '0;
    logic [CW-1:0]  inst_rep = '0;
    logic           uop_rdy;
    logic           uop_ack = 1'b0;
    logic [OPW-1:0] uop_opcode;
    logic [RW-1:0]  uop_dst;
    logic [RW-1:0]  uop_src0;
    logic [RW-1:0]  uop_src1;
    logic           uop_last;
    logic           o_busy;
`ifdef SIMD_SEQ_STAT_EN
    logic [31:0]    o_stat_inst;
    logic [31:0]    o_stat_stall;
`endif

    exp_t sb_q[$];
    int   xfer_cyc_q[$];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   accepted = 0;

    simd_inst_sequencer dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .inst_rdy    (inst_rdy),
        .inst_ack    (inst_ack),
        .inst_opcode (inst_opcode),
        .inst_dst    (inst_dst),
        .inst_src0   (inst_src0),
        .inst_src1   (inst_src1),
        .inst_rep    (inst_rep),
        .uop_rdy     (uop_rdy),
        .uop_ack     (uop_ack),
        .uop_opcode  (uop_opcode),
        .uop_dst     (uop_dst),
        .uop_src0    (uop_src0),
        .uop_src1    (uop_src1),
        .uop_last    (uop_last),
        .o_busy      (o_busy)
`ifdef SIMD_SEQ_STAT_EN
        ,
        .o_stat_inst (o_stat_inst),
        .o_stat_stall(o_stat_stall)
`endif
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expand accepted instructions, compare each micro-op transfer.
    always @(negedge i_clk) begin
        if (i_rst) begin
            if (uop_rdy && uop_ack) begin
                xfer_cyc_q.push_back(cyc);
                tests++;
                assert (sb_q.size() != 0) else begin
                    failed++;
                    $error("[TB] FAIL uop_unexpected observed=%0h expected=none",
                           {uop_opcode, uop_dst, uop_src0, uop_src1, uop_last});
                end
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    tests++;
                    assert ({uop_opcode, uop_dst, uop_src0, uop_src1, uop_last} === e) else begin
                        failed++;
                        $error("[TB] FAIL uop observed=%0h expected=%0h",
                               {uop_opcode, uop_dst, uop_src0, uop_src1, uop_last}, e);
                    end
                end
            end
            if (inst_rdy && inst_ack) begin
                accepted++;
                for (int k = 0; k <= int'(inst_rep); k++) begin
                    sb_q.push_back({inst_opcode, inst_dst + RW'(k), inst_src0 + RW'(k),
                                    inst_src1 + RW'(k), (k == int'(inst_rep))});
                end
            end
        end
    end

    task automatic offer_inst(input int op, input int dst, input int s0, input int s1, input int rep);
        inst_opcode = OPW'(op);
        inst_dst    = RW'(dst);
        inst_src0   = RW'(s0);
        inst_src1   = RW'(s1);
        inst_rep    = CW'(rep);
        inst_rdy    = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        bit done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge i_clk);
            if (inst_ack) done = 1;
        end
        @(posedge i_clk);
        #1;
        inst_rdy = 1'b0;
        if (!done) check_output({tag, "_accept_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic apply_stimulus(input int op, input int dst, input int s0, input int s1, input int rep);
        offer_inst(op, dst, s0, s1, rep);
        wait_accept("inst");
    endtask

    task automatic drain(input string tag);
        bit done = 0;
        for (int n = 0; n < 1000 && !done; n++) begin
            @(negedge i_clk);
            if (sb_q.size() == 0 && !uop_rdy) done = 1;
        end
        check_output({tag, "_drained"}, 64'(done), 64'd1);
        check_output({tag, "_busy_after"}, 64'(o_busy), 64'd0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int base;

        // 1. Reset held with an instruction offered.
        uop_ack = 1'b1;
        offer_inst(1, 5, 6, 7, 0);
        repeat (3) @(negedge i_clk);
        check_output("rst_inst_ack", 64'(inst_ack), 64'd0);
        check_output("rst_uop_rdy", 64'(uop_rdy), 64'd0);
        check_output("rst_busy", 64'(o_busy), 64'd0);
        check_output("rst_uop_fields", 64'({uop_opcode, uop_dst, uop_src0, uop_src1, uop_last}), 64'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        check_output("rel_first_ack", 64'(inst_ack), 64'd1);
        @(posedge i_clk);
        #1;
        inst_rdy = 1'b0;
        drain("t1");

        // 2. Single instruction with rep=2 and load latency.
        apply_stimulus(3, 10, 20, 30, 2);
        @(negedge i_clk);
        check_output("t2_lat_low", 64'(uop_rdy), 64'd0);
        @(negedge i_clk);
        check_output("t2_lat_high", 64'(uop_rdy), 64'd1);
        check_output("t2_first_dst", 64'(uop_dst), 64'd10);
        @(posedge i_clk);
        #1;
        drain("t2");

        // 3. Back-to-back rep=0 instructions: one uop per cycle.
        xfer_cyc_q.delete();
        for (int k = 0; k < 6; k++) apply_stimulus(k + 2, 3 * k, 3 * k + 1, 3 * k + 2, 0);
        drain("t3");
        check_output("t3_uop_count", 64'(xfer_cyc_q.size()), 64'd6);
        if (xfer_cyc_q.size() == 6)
            check_output("t3_no_bubble", 64'(xfer_cyc_q[5] - xfer_cyc_q[0]), 64'd5);

        // 4. Back-pressure with four instructions offered.
        uop_ack = 1'b0;
        base = accepted;
        apply_stimulus(5, 1, 2, 3, 1);
        apply_stimulus(6, 4, 5, 6, 0);
        offer_inst(7, 7, 8, 9, 0);
        for (int n = 0; n < 10; n++) begin
            @(negedge i_clk);
            check_output("t4_ack_low", 64'(inst_ack), 64'd0);
            check_output("t4_uop_hold", 64'({uop_rdy, uop_dst, uop_src0, uop_last}), 64'({1'b1, 6'd1, 6'd2, 1'b0}));
        end
        check_output("t4_accepted", 64'(accepted - base), 64'd2);
        @(posedge i_clk);
        #1;
        uop_ack = 1'b1;
        wait_accept("t4c");
        apply_stimulus(8, 10, 11, 12, 2);
        drain("t4");
        check_output("t4_accepted_all", 64'(accepted - base), 64'd4);

        // 5. Register wrap and maximum repeat count.
        apply_stimulus(9, 63, 62, 0, 3);
        drain("t5a");
        xfer_cyc_q.delete();
        apply_stimulus(10, 0, 1, 2, 255);
        drain("t5b");
        check_output("t5_uop_count", 64'(xfer_cyc_q.size()), 64'd256);
        if (xfer_cyc_q.size() == 256)
            check_output("t5_throughput", 64'(xfer_cyc_q[255] - xfer_cyc_q[0]), 64'd255);

        // 6. Reset in the middle of a burst.
        apply_stimulus(11, 5, 6, 7, 50);
        repeat (8) @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        #1;
        sb_q.delete();
        check_output("t6_uop_rdy", 64'(uop_rdy), 64'd0);
        check_output("t6_fields", 64'({uop_opcode, uop_dst, uop_src0, uop_src1, uop_last}), 64'd0);
        check_output("t6_busy", 64'(o_busy), 64'd0);
`ifdef SIMD_SEQ_STAT_EN
        check_output("t6_stat_inst_rst", 64'(o_stat_inst), 64'd0);
        check_output("t6_stat_stall_rst", 64'(o_stat_stall), 64'd0);
`endif
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        apply_stimulus(12, 40, 41, 42, 1);
        drain("t6");
`ifdef SIMD_SEQ_STAT_EN
        check_output("t6_stat_inst", 64'(o_stat_inst), 64'd1);
        check_output("t6_stat_stall", 64'(o_stat_stall), 64'd0);
`endif

        check_output("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
